// File: rtl/enumerate_solutions_gen.sv
// Enumerates every solution of a latched GF(2) system given in reduced row-echelon form.
// It either streams all solutions or only the earliest minimum-weight solution.
module enumerate_solutions_gen #(
    parameter int ROWS       = 2,
    parameter int COLS       = 3,
    parameter int DATA_WIDTH = 8,
    parameter int MIN_ONLY   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [COLS-1:0]       RREF [ROWS-1:0],
    output logic                  solution_stream_tvalid,
    output logic [DATA_WIDTH-1:0] solution_stream_tdata,
    output logic                  solution_stream_tlast,
    input  logic                  solution_stream_tready,
    output logic                  busy,
    output logic                  done,
    output logic                  inconsistent,
    output logic [$clog2(COLS):0] min_weight,
    output logic [2:0]            state_dbg
);

    localparam int NV = COLS - 1;
    localparam int WW = $clog2(COLS) + 1;
    localparam logic [NV-1:0] ONE_NV = NV'(1);
    localparam logic [NV:0]   ONE_A  = (NV + 1)'(1);

    generate
        if (NV > DATA_WIDTH) begin : g_width_check
            $error("enumerate_solutions_gen: COLS-1 variables do not fit in DATA_WIDTH");
        end
        if (NV < 1) begin : g_cols_check
            $error("enumerate_solutions_gen: COLS must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ANALYZE  = 3'd1,
        S_SCAN     = 3'd2,
        S_EMIT     = 3'd3,
        S_EMIT_ONE = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t state, state_n;

    logic [COLS-1:0] rref_q [ROWS-1:0];
    logic [NV-1:0]   free_q;
    logic [NV:0]     last_q;
    logic [NV:0]     a_q;
    logic [NV-1:0]   best_sol_q;
    logic [WW-1:0]   best_w_q;

    logic [NV-1:0]   piv_mask;
    logic [NV-1:0]   an_row;
    logic [NV:0]     last_val;
    logic            zero_bad;

    logic [NV-1:0]   exp_v;
    logic [NV:0]     a_sh;
    logic [NV-1:0]   sol_row;
    logic [NV-1:0]   cand_sol;
    logic [WW-1:0]   cand_w;
    logic            cand_better;
    logic            at_last;

    assign state_dbg = state;
    assign at_last   = (a_q == last_q);

    // Row pivot = lowest set variable bit, isolated with v & -v.
    always_comb begin
        piv_mask = '0;
        an_row   = '0;
        zero_bad = 1'b0;
        last_val = '0;
        for (int r = 0; r < ROWS; r++) begin
            an_row = rref_q[r][NV-1:0];
            if (an_row == '0) begin
                if (rref_q[r][NV]) zero_bad = 1'b1;
            end else begin
                piv_mask = piv_mask | (an_row & (~an_row + ONE_NV));
            end
        end
        for (int c = 0; c < NV; c++) begin
            if (!piv_mask[c]) last_val = {last_val[NV-1:0], 1'b1};
        end
    end

    // Scatter the assignment over the free columns, then solve each pivot.
    always_comb begin
        exp_v    = '0;
        a_sh     = a_q;
        sol_row  = '0;
        cand_w   = '0;
        for (int c = 0; c < NV; c++) begin
            if (free_q[c]) begin
                exp_v[c] = a_sh[0];
                a_sh     = a_sh >> 1;
            end
        end
        cand_sol = exp_v;
        for (int r = 0; r < ROWS; r++) begin
            sol_row = rref_q[r][NV-1:0];
            if (sol_row != '0) begin
                if ((^(sol_row & free_q & exp_v)) ^ rref_q[r][NV])
                    cand_sol = cand_sol | (sol_row & (~sol_row + ONE_NV));
            end
        end
        for (int c = 0; c < NV; c++) begin
            cand_w = cand_w + WW'(cand_sol[c]);
        end
        cand_better = (a_q == '0) || (cand_w < best_w_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Stream handshake: a beat transfers on a cycle where tvalid && tready; while
    // tvalid is high and tready is low, tdata and tlast hold and tvalid never drops.
    always_comb begin
        state_n                = state;
        busy                   = 1'b0;
        done                   = 1'b0;
        solution_stream_tvalid = 1'b0;
        solution_stream_tdata  = '0;
        solution_stream_tlast  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_n = S_ANALYZE;
            end
            S_ANALYZE: begin
                busy = 1'b1;
                if (zero_bad)           state_n = S_DONE;
                else if (MIN_ONLY != 0) state_n = S_SCAN;
                else                    state_n = S_EMIT;
            end
            S_SCAN: begin
                busy = 1'b1;
                if (at_last) state_n = S_EMIT_ONE;
            end
            S_EMIT: begin
                busy                              = 1'b1;
                solution_stream_tvalid            = 1'b1;
                solution_stream_tdata[NV-1:0]     = cand_sol;
                solution_stream_tlast             = at_last;
                if (solution_stream_tready && at_last) state_n = S_DONE;
            end
            S_EMIT_ONE: begin
                busy                              = 1'b1;
                solution_stream_tvalid            = 1'b1;
                solution_stream_tdata[NV-1:0]     = best_sol_q;
                solution_stream_tlast             = 1'b1;
                if (solution_stream_tready) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) rref_q[r] <= '0;
            free_q       <= '0;
            last_q       <= '0;
            a_q          <= '0;
            best_sol_q   <= '0;
            best_w_q     <= '0;
            inconsistent <= 1'b0;
            min_weight   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rref_q       <= RREF;
                        a_q          <= '0;
                        inconsistent <= 1'b0;
                        min_weight   <= '0;
                    end
                end
                S_ANALYZE: begin
                    free_q <= ~piv_mask;
                    last_q <= last_val;
                    a_q    <= '0;
                    if (zero_bad) inconsistent <= 1'b1;
                end
                S_SCAN: begin
                    if (cand_better) begin
                        best_sol_q <= cand_sol;
                        best_w_q   <= cand_w;
                    end
                    if (at_last) min_weight <= cand_better ? cand_w : best_w_q;
                    else         a_q <= a_q + ONE_A;
                end
                S_EMIT: begin
                    if (solution_stream_tready && !at_last) a_q <= a_q + ONE_A;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_enumerate_solutions_gen.sv
// Bench for enumerate_solutions_gen: one streaming instance and one minimum-weight instance
// share stimulus; a brute-force solver over all variable assignments predicts their output.
module tb_enumerate_solutions_gen;

    localparam int ROWS = 3;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int NV   = COLS - 1;
    localparam int MWW  = $clog2(COLS) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic tready = 1'b1;
    logic [COLS-1:0] rref [ROWS-1:0];
    always #5 clk = ~clk;

    logic           tv_a, tl_a, busy_a, done_a, inc_a;
    logic [DW-1:0]  td_a;
    logic [MWW-1:0] mw_a;
    logic [2:0]     st_a;
    logic           tv_m, tl_m, busy_m, done_m, inc_m;
    logic [DW-1:0]  td_m;
    logic [MWW-1:0] mw_m;
    logic [2:0]     st_m;

    enumerate_solutions_gen #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .MIN_ONLY(0)) u_all (
        .clk(clk), .rst_n(rst_n), .start(start), .RREF(rref),
        .solution_stream_tvalid(tv_a), .solution_stream_tdata(td_a),
        .solution_stream_tlast(tl_a), .solution_stream_tready(tready),
        .busy(busy_a), .done(done_a), .inconsistent(inc_a), .min_weight(mw_a),
        .state_dbg(st_a)
    );

    enumerate_solutions_gen #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .MIN_ONLY(1)) u_min (
        .clk(clk), .rst_n(rst_n), .start(start), .RREF(rref),
        .solution_stream_tvalid(tv_m), .solution_stream_tdata(td_m),
        .solution_stream_tlast(tl_m), .solution_stream_tready(tready),
        .busy(busy_m), .done(done_m), .inconsistent(inc_m), .min_weight(mw_m),
        .state_dbg(st_m)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int passes = 0;
    int done_cnt_a = 0;
    int done_cnt_m = 0;
    int tready_mode = 0;
    logic [DW:0]  exp_q_a[$];
    logic [DW:0]  exp_q_m[$];
    logic [MWW:0] done_q_a[$];
    logic [MWW:0] done_q_m[$];
    logic         stall_a = 1'b0;
    logic         stall_m = 1'b0;
    logic [DW:0]  stall_d_a, stall_d_m, mon_e_a, mon_e_m;
    logic [MWW:0] mon_d_a, mon_d_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // ---------------- driver tasks ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 0)      tready = 1'b1;
            else if (tready_mode == 1) tready = ($urandom_range(0, 3) != 0);
            else                       tready = 1'b0;
        end
    end

    // Reference: solve by trying every variable vector, then order the solutions by
    // the value formed from their free-variable bits.
    task automatic push_expected(input logic [COLS-1:0] m [ROWS-1:0], output bit consistent);
        logic [NV-1:0] piv, free, xv, best;
        logic [NV-1:0] sol_by_key [1<<NV];
        int nsol, key, k, lo, bw, w;
        bit ok;
        piv = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (m[r][NV-1:0] != '0) begin
                lo = 0;
                for (int c = NV - 1; c >= 0; c--) if (m[r][c]) lo = c;
                piv[lo] = 1'b1;
            end
        end
        free = ~piv;
        nsol = 0;
        for (int x = 0; x < (1 << NV); x++) begin
            xv = NV'(x);
            ok = 1'b1;
            for (int r = 0; r < ROWS; r++)
                if ((^(m[r][NV-1:0] & xv)) != m[r][NV]) ok = 1'b0;
            if (ok) begin
                key = 0;
                k = 0;
                for (int c = 0; c < NV; c++) begin
                    if (free[c]) begin
                        if (xv[c]) key += (1 << k);
                        k++;
                    end
                end
                sol_by_key[key] = xv;
                nsol++;
            end
        end
        consistent = (nsol > 0);
        if (!consistent) begin
            done_q_a.push_back({1'b1, MWW'(0)});
            done_q_m.push_back({1'b1, MWW'(0)});
        end else begin
            bw = NV + 1;
            best = '0;
            for (int i = 0; i < nsol; i++) begin
                exp_q_a.push_back({(i == nsol - 1), DW'(sol_by_key[i])});
                w = $countones(sol_by_key[i]);
                if (w < bw) begin
                    bw = w;
                    best = sol_by_key[i];
                end
            end
            exp_q_m.push_back({1'b1, DW'(best)});
            done_q_a.push_back({1'b0, MWW'(0)});
            done_q_m.push_back({1'b0, MWW'(bw)});
        end
    endtask

    task automatic gen_rref(output logic [COLS-1:0] m [ROWS-1:0]);
        logic [NV-1:0]   pm, hi;
        logic [COLS-1:0] tmp;
        int r, i, j;
        pm = NV'($urandom_range(0, (1 << NV) - 1));
        r = 0;
        for (int c = 0; c < NV; c++) begin
            if (pm[c]) begin
                hi = '0;
                for (int q = c + 1; q < NV; q++) if (!pm[q]) hi[q] = 1'b1;
                m[r] = '0;
                m[r][NV-1:0] = (NV'(1) << c) | (hi & NV'($urandom));
                m[r][NV] = 1'($urandom_range(0, 1));
                r++;
            end
        end
        while (r < ROWS) begin
            m[r] = '0;
            m[r][NV] = ($urandom_range(0, 3) == 0);
            r++;
        end
        i = $urandom_range(0, ROWS - 1);
        j = $urandom_range(0, ROWS - 1);
        tmp = m[i];
        m[i] = m[j];
        m[j] = tmp;
    endtask

    task automatic scramble_rref();
        for (int r = 0; r < ROWS; r++) rref[r] = COLS'($urandom_range(0, (1 << COLS) - 1));
    endtask

    task automatic run_case(input logic [COLS-1:0] m [ROWS-1:0], input int mode, input bit extra_start);
        bit consistent;
        int base_a, base_m, cyc;
        push_expected(m, consistent);
        tready_mode = mode;
        @(posedge clk);
        #1;
        rref = m;
        start = 1'b1;
        base_a = done_cnt_a;
        base_m = done_cnt_m;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_rref();
        check("busy_after_start", busy_a, 1);
        check("no_valid_in_analyze", tv_a, 0);
        check("incons_cleared_on_start", inc_a, 0);
        check("min_weight_cleared_on_start", mw_m, 0);
        @(posedge clk);
        #1;
        check("first_beat_latency", tv_a, consistent);
        if (extra_start) begin
            start = 1'b1;
            scramble_rref();
            @(posedge clk);
            #1;
            start = 1'b0;
            @(posedge clk);
            #1;
            tready_mode = 0;
            tready = 1'b1;
        end
        cyc = 0;
        while ((done_cnt_a == base_a || done_cnt_m == base_m) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (cyc >= 3000) fail_now("done_timeout");
        repeat (2) @(posedge clk);
        #1;
        check("one_done_all", done_cnt_a - base_a, 1);
        check("one_done_min", done_cnt_m - base_m, 1);
        tready_mode = 0;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_a <= 1'b0;
        end else begin
            if (tv_a && tready) begin
                if (exp_q_a.size() == 0) fail_now("beat_unexpected_all");
                else begin
                    mon_e_a = exp_q_a.pop_front();
                    check("beat_all", {tl_a, td_a}, mon_e_a);
                end
            end
            if (stall_a) begin
                check("hold_valid_all", tv_a, 1);
                check("hold_data_all", {tl_a, td_a}, stall_d_a);
            end
            stall_a <= tv_a && !tready;
            stall_d_a <= {tl_a, td_a};
            if (done_a) begin
                done_cnt_a++;
                check("busy_at_done_all", busy_a, 0);
                check("beats_left_all", exp_q_a.size(), 0);
                if (done_q_a.size() == 0) fail_now("done_unexpected_all");
                else begin
                    mon_d_a = done_q_a.pop_front();
                    check("done_flags_all", {inc_a, mw_a}, mon_d_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_m <= 1'b0;
        end else begin
            if (tv_m && tready) begin
                if (exp_q_m.size() == 0) fail_now("beat_unexpected_min");
                else begin
                    mon_e_m = exp_q_m.pop_front();
                    check("beat_min", {tl_m, td_m}, mon_e_m);
                end
            end
            if (stall_m) begin
                check("hold_valid_min", tv_m, 1);
                check("hold_data_min", {tl_m, td_m}, stall_d_m);
            end
            stall_m <= tv_m && !tready;
            stall_d_m <= {tl_m, td_m};
            if (done_m) begin
                done_cnt_m++;
                check("busy_at_done_min", busy_m, 0);
                check("beats_left_min", exp_q_m.size(), 0);
                if (done_q_m.size() == 0) fail_now("done_unexpected_min");
                else begin
                    mon_d_m = done_q_m.pop_front();
                    check("done_flags_min", {inc_m, mw_m}, mon_d_m);
                end
            end
        end
    end

    // ---------------- main sequence and final report ----------------
    logic [COLS-1:0] mat [ROWS-1:0];

    initial begin
        for (int r = 0; r < ROWS; r++) rref[r] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_all", {tv_a, tl_a, busy_a, done_a, inc_a, mw_a, td_a, st_a}, 0);
        check("reset_outputs_min", {tv_m, tl_m, busy_m, done_m, inc_m, mw_m, td_m, st_m}, 0);
        rst_n = 1'b1;

        // two pivots, one free variable: solutions 001 then 100, tie keeps 001
        mat[0] = 4'b1101; mat[1] = 4'b0010; mat[2] = 4'b0000;
        run_case(mat, 0, 1'b0);

        // all-zero matrix: every vector, no wrap
        mat[0] = 4'b0000; mat[1] = 4'b0000; mat[2] = 4'b0000;
        run_case(mat, 0, 1'b0);

        // no free variables: exactly one beat
        mat[0] = 4'b1001; mat[1] = 4'b0010; mat[2] = 4'b1100;
        run_case(mat, 0, 1'b0);

        // zero row with RHS set: no beats, inconsistent held until next start
        mat[0] = 4'b1000; mat[1] = 4'b0001; mat[2] = 4'b0000;
        run_case(mat, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("incons_held_all", inc_a, 1);
        check("incons_held_min", inc_m, 1);
        check("idle_after_incons", busy_a, 0);

        // backpressure on the first beat plus an ignored second start
        mat[0] = 4'b1101; mat[1] = 4'b0010; mat[2] = 4'b0000;
        run_case(mat, 2, 1'b1);

        // asynchronous reset in the middle of a stalled frame
        mat[0] = 4'b0000; mat[1] = 4'b0000; mat[2] = 4'b0000;
        tready_mode = 2;
        @(posedge clk);
        #1;
        rref = mat;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        check("pre_reset_valid", tv_a, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_valid_all", tv_a, 0);
        check("reset_mid_busy_all", busy_a, 0);
        check("reset_mid_done_all", done_a, 0);
        check("reset_mid_state_all", st_a, 0);
        check("reset_mid_min", {tv_m, busy_m, done_m}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tready_mode = 0;
        tready = 1'b1;
        run_case(mat, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            gen_rref(mat);
            run_case(mat, $urandom_range(0, 1), 1'b0);
        end

        check("final_beats_left_all", exp_q_a.size(), 0);
        check("final_beats_left_min", exp_q_m.size(), 0);
        check("final_dones_left", done_q_a.size() + done_q_m.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/enumerate_solutions_gen.md
Name: enumerate_solutions_gen

Overview:
- Parametrised successor to the GF(2) solution enumerator.
- Takes a latched reduced-row-echelon augmented matrix over GF(2).
- Detects inconsistent systems, identifies pivot and free variables, and walks all 2^F free-variable assignments.
- Mode parameter selects one of two outputs: every solution streamed, or only the minimum-Hamming-weight solution plus its weight. Sits between the RREF reducer and the per-machine answer accumulator.

Parameters:
- ROWS, 2: matrix rows.
- COLS, 3: matrix columns. Bits [COLS-2:0] are variables x0..x(COLS-2); bit COLS-1 is the RHS. NV = COLS-1 variables.
- DATA_WIDTH, 8: stream tdata width. Elaboration error if NV > DATA_WIDTH.
- MIN_ONLY, 0: 0 = stream all solutions; 1 = stream one minimum-weight solution.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- RREF  in  [COLS-1:0] x ROWS (unpacked [ROWS-1:0])  augmented RREF matrix; latched on accepted start.
- solution_stream  axi_stream_if master modport, DATA_WIDTH  tvalid/tdata/tlast out, tready in.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- inconsistent  out  1  valid from done until next accepted start.
- min_weight  out  $clog2(COLS)+1  minimum popcount found. Valid with done when MIN_ONLY=1; 0 otherwise.

Behaviour:
- Reset (async, any state): state IDLE. tvalid, tlast, busy, done, inconsistent, min_weight = 0. tdata = 0. Internal counter cleared.
- Pivot rule: a row's pivot is its lowest set bit in [NV-1:0]. Rows with no variable bits are zero rows. Columns that are not any row's pivot are free variables. Free var k is the k-th free column in ascending index order.
- Inconsistency: any zero-variable row with RHS = 1.
- Solution for assignment a:
  - Free columns take the bits of a.
  - Each pivot column p_r = RHS_r XOR parity(row_r[NV-1:0] & free_mask & expand(a)).
  - tdata = solution zero-extended to DATA_WIDTH.
- States:
  - IDLE: start -> latch RREF, busy=1 -> ANALYZE.
  - ANALYZE: 1 cycle. Computes pivot mask, free mask, F and inconsistency. Next state: inconsistent -> DONE; else MIN_ONLY=0 -> EMIT with a=0; else SCAN with a=0.
  - SCAN (MIN_ONLY=1): evaluates one candidate per cycle for 2^F cycles. Keeps the strictly-lower-weight candidate, so ties keep the earliest a. After a = 2^F-1 -> EMIT_ONE.
  - EMIT (MIN_ONLY=0): tvalid=1 with the solution for a; tlast=1 when a = 2^F-1. On tvalid&&tready: a++ (or -> DONE after the last beat). tdata/tlast stay stable while tready=0. Throughput is 1 beat/cycle with tready held high.
  - EMIT_ONE: tvalid=1, tdata = best solution, tlast=1. Handshake -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- First beat: tvalid is asserted 2 cycles after the start cycle.
- start while busy is ignored. RREF changes after the latch have no effect.
- Counter width NV+1 bits; F=0 gives exactly one beat. F=NV (all-zero matrix) gives 2^NV beats with no wrap.
- Inconsistent systems emit no beats.
- Reset mid-EMIT drops tvalid immediately (async). No partial-frame recovery.

Test Plan:
- 2x3, RREF={3'b110, 3'b101} (row1, row0), MIN_ONLY=0, tready=1 -> one beat tdata=8'h03 tlast=1; done 1 cycle later; inconsistent=0.
- 3x4, row0=4'b1101, row1=4'b0010, row2=0, MIN_ONLY=0 -> beats 8'h01 then 8'h04 (tlast on second). Same matrix with MIN_ONLY=1 -> single beat 8'h01, tlast=1, min_weight=1 (tie keeps first).
- 2x3 all-zero RREF -> beats 8'h00, 8'h01, 8'h02, 8'h03; tlast only on 8'h03.
- 2x3, row0=3'b101, row1=3'b100 -> no tvalid ever; done pulse with inconsistent=1, busy drops.
- Backpressure: 3x4 case with tready=0 for 3 cycles on the first beat -> tdata=8'h01 and tvalid held stable; resumes with 8'h04. A second start during EMIT is ignored.
- Assert rst_n=0 mid-EMIT -> tvalid, busy, done all 0 same cycle; a fresh start afterwards re-enumerates from a=0.
